jtkiwi_gfx_rom: RTL

Responder side of the graphics ROM request interface. Serves the tilemap (`scr_*`) and object (`obj_*`) ROM clients of the Kiwi graphics block from one 16-bit SDRAM read slot. For each client it keeps a one-entry 32-bit cache, assembles each 32-bit word from a two-beat SDRAM burst, and returns data with an `ok` handshake. It sits between the graphics block and the SDRAM controller.

---
 rtl/jtkiwi_rom_pkg.sv | 17 +
 rtl/jtkiwi_rom_cache.sv | 35 +++
 rtl/jtkiwi_gfx_rom.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/jtkiwi_rom_pkg.sv
// Shared constants for the Kiwi graphics ROM responder: FSM encoding, client ids, widths.
package jtkiwi_rom_pkg;

    localparam int TAG_W = 18;
    localparam int SDW   = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LO   = 2'd2,
        ST_HI   = 2'd3
    } rom_state_t;

    localparam logic CLI_SCR = 1'b0;
    localparam logic CLI_OBJ = 1'b1;

endpackage

// File: rtl/jtkiwi_rom_cache.sv
// One-entry 32-bit cache for a single ROM client; ok is combinational from the stored tag.
module jtkiwi_rom_cache
    import jtkiwi_rom_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_i,
    input  logic [TAG_W-1:0] addr_i,
    output logic             ok_o,
    output logic [31:0]      data_o,
    input  logic             we_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [31:0]      din_i
);

    logic [TAG_W-1:0] tag_q;
    logic             valid_q;
    logic [31:0]      data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (we_i) begin
            tag_q   <= tag_i;
            valid_q <= 1'b1;
            data_q  <= din_i;
        end
    end

    assign ok_o   = cs_i & valid_q & (tag_q == addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/jtkiwi_gfx_rom.sv
// Graphics ROM responder: serves tile/object clients from one 16-bit SDRAM slot.
// Optional macro JTKIWI_OBJ_EN enables the object client; otherwise only scr is served.
module jtkiwi_gfx_rom
    import jtkiwi_rom_pkg::*;
#(
    parameter logic [21:0] SCR_BASE = 22'h0,
    parameter logic [21:0] OBJ_BASE = 22'h100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scr_cs,
    input  logic [TAG_W-1:0] scr_addr,
    output logic [31:0]      scr_data,
    output logic             scr_ok,
    input  logic             obj_cs,
    input  logic [TAG_W-1:0] obj_addr,
    output logic [31:0]      obj_data,
    output logic             obj_ok,
    output logic             sdram_req,
    output logic [SDW-1:0]   sdram_addr,
    input  logic             sdram_ack,
    input  logic             sdram_rdy,
    input  logic [15:0]      sdram_din
);

    rom_state_t       state_q, state_d;
    logic             req_q, req_d;
    logic [SDW-1:0]   addr_q, addr_d;
    logic             cli_q, cli_d;
    logic             last_q, last_d;
    logic [TAG_W-1:0] req_tag_q;
    logic [15:0]      lo_q;
    logic             tag_ld, lo_we, fill;
    logic             scr_miss, obj_miss, do_req, pick_obj;
    logic [SDW-1:0]   req_addr;
    logic [31:0]      fill_data;

    assign fill_data = {sdram_din, lo_q};

    jtkiwi_rom_cache u_scr (
        .clk    (clk),
        .rst_n  (rst_n),
        .cs_i   (scr_cs),
        .addr_i (scr_addr),
        .ok_o   (scr_ok),
        .data_o (scr_data),
        .we_i   (fill & (cli_q == CLI_SCR)),
        .tag_i  (req_tag_q),
        .din_i  (fill_data)
    );

`ifdef JTKIWI_OBJ_EN
    jtkiwi_rom_cache u_obj (
        .clk    (clk),
        .rst_n  (rst_n),
        .cs_i   (obj_cs),
        .addr_i (obj_addr),
        .ok_o   (obj_ok),
        .data_o (obj_data),
        .we_i   (fill & (cli_q == CLI_OBJ)),
        .tag_i  (req_tag_q),
        .din_i  (fill_data)
    );
    assign obj_miss = obj_cs & ~obj_ok;
`else
    logic unused_obj;
    assign unused_obj = obj_cs;
    assign obj_ok     = 1'b0;
    assign obj_data   = '0;
    assign obj_miss   = 1'b0;
`endif

    assign scr_miss = scr_cs & ~scr_ok;
    assign do_req   = scr_miss | obj_miss;
    // On a double miss the client that was not served last goes first.
    assign pick_obj = (scr_miss & obj_miss) ? (last_q == CLI_SCR) : obj_miss;
    assign req_addr = pick_obj ? OBJ_BASE + {3'b0, obj_addr, 1'b0}
                               : SCR_BASE + {3'b0, scr_addr, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            cli_q   <= CLI_SCR;
            last_q  <= CLI_OBJ;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            cli_q   <= cli_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (do_req)    state_d = ST_REQ;
            ST_REQ:  if (sdram_ack) state_d = sdram_rdy ? ST_HI : ST_LO;
            ST_LO:   if (sdram_rdy) state_d = ST_HI;
            ST_HI:   if (sdram_rdy) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        cli_d  = cli_q;
        last_d = last_q;
        tag_ld = 1'b0;
        lo_we  = 1'b0;
        fill   = 1'b0;
        case (state_q)
            ST_IDLE: if (do_req) begin
                req_d  = 1'b1;
                addr_d = req_addr;
                cli_d  = pick_obj;
                last_d = pick_obj;
                tag_ld = 1'b1;
            end
            ST_REQ: if (sdram_ack) begin
                req_d = 1'b0;
                lo_we = sdram_rdy;
            end
            ST_LO:   lo_we = sdram_rdy;
            ST_HI:   fill  = sdram_rdy;
            default: ;
        endcase
    end

    // Request tag and low half-word are plain data, loaded only under FSM control.
    always_ff @(posedge clk) begin
        if (tag_ld) req_tag_q <= pick_obj ? obj_addr : scr_addr;
        if (lo_we)  lo_q      <= sdram_din;
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

endmodule
